// File: rtl/switch_input_debouncer.sv
// Synchronises and debounces {sw_sel, sw_data} as one 5-bit group. The debounced value feeds the converter's sel/data_in.
// Latency: DEBOUNCE_CYCLES+2 edges from the first sampling edge to the commit. There is no backpressure, and inputs are sampled every cycle.
// Optional build macro CHANGE_CNT_EN adds an 8-bit count of accepted changes that wraps at 255.
module switch_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw_data,
  input  logic       sw_sel,
  output logic [3:0] data_out,
  output logic       sel_out,
  output logic       changed,
  output logic       settling
`ifdef CHANGE_CNT_EN
  ,
  output logic [7:0] change_count
`endif
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       sync1_q;
  logic [4:0]       sync2_q;
  logic [4:0]       stable_q,  stable_d;
  logic [4:0]       cand_q,    cand_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             changed_q, changed_d;
  state_t           state_q,   state_d;

  // Plain two-flop synchroniser: nothing sits between the two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {sw_sel, sw_data};
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (sync2_q != stable_q) begin
          cand_d  = sync2_q;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (sync2_q == stable_q) begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (sync2_q != cand_q) begin
          // A bounce to a different value restarts the window on that value.
          cand_d = sync2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          stable_d  = cand_q;
          changed_d = 1'b1;
          cnt_d     = '0;
          state_d   = ST_STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_STABLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STABLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

`ifdef CHANGE_CNT_EN
  logic [7:0] chg_cnt_q, chg_cnt_d;

  always_comb begin
    chg_cnt_d = chg_cnt_q;
    if (changed_d) chg_cnt_d = chg_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chg_cnt_q <= '0;
    else        chg_cnt_q <= chg_cnt_d;
  end

  assign change_count = chg_cnt_q;
`endif

  assign data_out = stable_q[3:0];
  assign sel_out  = stable_q[4];
  assign changed  = changed_q;
  assign settling = (state_q == ST_SETTLE);

endmodule
